quet_led_7doan_n: RTL
=====================

QUET_LED_7DOAN_N -- requirements
Module: quet_led_7doan_n

Interface
REQ-001 Parameter N_DIGIT, default 4: digit count, legal range 2..8.
REQ-002 Parameter REFRESH_CNT, default 50000: clock cycles per digit slot, minimum 4.
REQ-003 Parameter BLANK_CYC, default 2: anti-ghost blank cycles at each slot start, range 0..REFRESH_CNT-2.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 so_gma  input  4*N_DIGIT  hex nibbles; digit i is so_gma[4i+3:4i]; digit 0 is rightmost.
REQ-007 dp_in  input  N_DIGIT  per-digit decimal point request, 1 = lit.
REQ-008 blank  input  N_DIGIT  per-digit force-off, 1 = dark.
REQ-009 lz_en  input  1  leading-zero suppression enable.
REQ-010 load  input  1  one-cycle strobe capturing so_gma, dp_in and blank into the shadow register.
REQ-011 an  output  N_DIGIT  anode enables, active-low, registered.
REQ-012 sseg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 dp  output  1  decimal point, active-low, registered.
REQ-014 frame_done  output  1  one-cycle pulse when digit N_DIGIT-1 slot ends.

Function
REQ-015 Refresh counter SHALL count 0..REFRESH_CNT-1 and wrap to 0; its terminal count SHALL advance the digit index.
REQ-016 Digit index SHALL run 0,1,..,N_DIGIT-1 and wrap to 0, with exactly one step per terminal count.
REQ-017 load=1 SHALL capture the inputs into the shadow register on that edge; the last load in a frame wins.
REQ-018 Shadow SHALL copy to the display register only on the cycle the index wraps N_DIGIT-1->0, so no frame shows mixed data.
REQ-019 load coinciding with the wrap cycle SHALL be seen at the next wrap, not the current one.
REQ-020 Encoding SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 With lz_en=1, each digit i>=1 whose nibble and all higher nibbles are 0 SHALL be dark; digit 0 SHALL never be suppressed.
REQ-022 A dark digit (blank, suppressed, or blank interval) SHALL drive sseg=1111111 and dp=1.
REQ-023 A blanked digit's anode SHALL still be driven low in its slot; a suppressed digit's anode SHALL also stay low.
REQ-024 During counter values 0..BLANK_CYC-1 of every slot, an SHALL be all ones, sseg=1111111 and dp=1.
REQ-025 Outside the blank interval, an SHALL be low on bit index only; dp SHALL equal ~dp_in of that digit unless dark.
REQ-026 Outputs SHALL lag the counter/index state that produces them by exactly one clock.
REQ-027 frame_done SHALL assert for one cycle, aligned with the registered outputs of the first cycle of the digit-0 slot.
REQ-028 lz_en SHALL be sampled live, not through the shadow register.

Reset
REQ-029 reset SHALL override load and all other inputs on the same edge.
REQ-030 Reset values: counter 0, index 0, shadow and display registers 0, an all ones, sseg 1111111, dp 1, frame_done 0.
REQ-031 Reset mid-frame SHALL abort the scan; after release the first active slot SHALL be digit 0 and show value 0.

Verification
REQ-032 N=4, REFRESH_CNT=4, BLANK_CYC=1; load so_gma=16'h12AF, dp_in=0, blank=0, lz_en=0 -> after the next wrap, per slot: an 1110/sseg 0001110, 1101/0001000, 1011/0100100, 0111/1111001; each slot has 1 dark cycle then 3 lit cycles.
REQ-033 so_gma=16'h0050, lz_en=1 -> digits 3 and 2 dark with an still toggling; digit 1 shows 0010010; digit 0 shows 1000000. Repeat with so_gma=16'h0000 -> only digit 0 lit, showing 1000000.
REQ-034 Load 16'h1111 then 16'h2222 in the same frame, then 16'h3333 on the wrap cycle -> next frame shows all 0100100; the following frame shows all 0110000.
REQ-035 dp_in=4'b0100, blank=4'b0001 -> dp=0 only in the digit-2 lit cycles; digit 0 slot has anode low and sseg 1111111.
REQ-036 Assert reset during the digit-2 slot, held 3 cycles with load=1 -> outputs at reset values during reset; after release the first lit slot is digit 0 showing 1000000; frame_done pulses every 16 cycles.

Source files
------------

// File: rtl/quet_led_7doan_n.sv
// ============================================================================
//  Module   : quet_led_7doan_n
//  Brief    : Time-multiplexed N-digit seven-segment scanner with frame-atomic
//             shadow/display buffering, leading-zero suppression and anti-ghost
//             blanking at every slot start.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quet_led_7doan_n #(
    parameter int N_DIGIT     = 4,
    parameter int REFRESH_CNT = 50000,
    parameter int BLANK_CYC   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*N_DIGIT-1:0]   so_gma,
    input  logic [N_DIGIT-1:0]     dp_in,
    input  logic [N_DIGIT-1:0]     blank,
    input  logic                   lz_en,
    input  logic                   load,
    output logic [N_DIGIT-1:0]     an,
    output logic [6:0]             sseg,
    output logic                   dp,
    output logic                   frame_done
);

    localparam int                   c_cnt_w   = $clog2(REFRESH_CNT);
    localparam int                   c_idx_w   = $clog2(N_DIGIT);
    localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(REFRESH_CNT - 1);
    localparam logic [c_cnt_w-1:0]   c_blank   = c_cnt_w'(BLANK_CYC);
    localparam logic [c_idx_w-1:0]   c_idx_max = c_idx_w'(N_DIGIT - 1);
    localparam logic [N_DIGIT-1:0]   c_one     = {{(N_DIGIT-1){1'b0}}, 1'b1};

    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_idx;
    logic [4*N_DIGIT-1:0] r_shd_dig;
    logic [N_DIGIT-1:0]   r_shd_dp;
    logic [N_DIGIT-1:0]   r_shd_blank;
    logic [4*N_DIGIT-1:0] r_dsp_dig;
    logic [N_DIGIT-1:0]   r_dsp_dp;
    logic [N_DIGIT-1:0]   r_dsp_blank;
    logic                 r_wrapped;
    logic [N_DIGIT-1:0]   r_an;
    logic [6:0]           r_sseg;
    logic                 r_dp;
    logic                 r_fd;

    logic                 w_tc;
    logic                 w_wrap;
    logic                 w_in_blank;
    logic [3:0]           w_nib;
    logic                 w_dp_req;
    logic                 w_blank_req;
    logic                 w_hi_zero;
    logic                 w_supp;
    logic                 w_dark;
    logic [N_DIGIT-1:0]   w_an_nxt;
    logic [6:0]           w_sseg_nxt;
    logic                 w_dp_nxt;

    function automatic logic [6:0] enc7(input logic [3:0] v);
        enc7 = 7'b1111111;
        case (v)
            4'h0: enc7 = 7'b1000000;
            4'h1: enc7 = 7'b1111001;
            4'h2: enc7 = 7'b0100100;
            4'h3: enc7 = 7'b0110000;
            4'h4: enc7 = 7'b0011001;
            4'h5: enc7 = 7'b0010010;
            4'h6: enc7 = 7'b0000010;
            4'h7: enc7 = 7'b1111000;
            4'h8: enc7 = 7'b0000000;
            4'h9: enc7 = 7'b0010000;
            4'hA: enc7 = 7'b0001000;
            4'hB: enc7 = 7'b0000011;
            4'hC: enc7 = 7'b1000110;
            4'hD: enc7 = 7'b0100001;
            4'hE: enc7 = 7'b0000110;
            4'hF: enc7 = 7'b0001110;
        endcase
    endfunction

    assign w_tc       = (r_cnt == c_cnt_max);
    assign w_wrap     = w_tc && (r_idx == c_idx_max);
    assign w_in_blank = (r_cnt < c_blank);

    // Scan position: slot counter and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            if (w_tc) begin
                r_cnt <= '0;
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Display only takes the shadow at the frame wrap, so a frame never mixes
    // old and new data; a load on the wrap edge lands in the shadow too late.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shd_dig   <= '0;
            r_shd_dp    <= '0;
            r_shd_blank <= '0;
            r_dsp_dig   <= '0;
            r_dsp_dp    <= '0;
            r_dsp_blank <= '0;
        end else begin
            if (load) begin
                r_shd_dig   <= so_gma;
                r_shd_dp    <= dp_in;
                r_shd_blank <= blank;
            end
            if (w_wrap) begin
                r_dsp_dig   <= r_shd_dig;
                r_dsp_dp    <= r_shd_dp;
                r_dsp_blank <= r_shd_blank;
            end
        end
    end

    // Select the active digit and evaluate suppression from the top down.
    always_comb begin
        w_nib       = 4'h0;
        w_dp_req    = 1'b0;
        w_blank_req = 1'b0;
        w_hi_zero   = 1'b1;
        w_supp      = 1'b0;
        for (int i = N_DIGIT - 1; i >= 0; i--) begin
            w_hi_zero = w_hi_zero && (r_dsp_dig[4*i +: 4] == 4'h0);
            if (r_idx == c_idx_w'(i)) begin
                w_nib       = r_dsp_dig[4*i +: 4];
                w_dp_req    = r_dsp_dp[i];
                w_blank_req = r_dsp_blank[i];
                w_supp      = lz_en && (i != 0) && w_hi_zero;
            end
        end
    end

    assign w_dark = w_blank_req | w_supp;

    always_comb begin
        w_an_nxt   = '1;
        w_sseg_nxt = 7'b1111111;
        w_dp_nxt   = 1'b1;
        if (!w_in_blank) begin
            w_an_nxt = ~(c_one << r_idx);
            if (!w_dark) begin
                w_sseg_nxt = enc7(w_nib);
                w_dp_nxt   = ~w_dp_req;
            end
        end
    end

    // r_wrapped marks the first cycle of the digit-0 slot; delaying it once
    // more lines frame_done up with that cycle's registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrapped <= 1'b0;
            r_fd      <= 1'b0;
            r_an      <= '1;
            r_sseg    <= 7'b1111111;
            r_dp      <= 1'b1;
        end else begin
            r_wrapped <= w_wrap;
            r_fd      <= r_wrapped;
            r_an      <= w_an_nxt;
            r_sseg    <= w_sseg_nxt;
            r_dp      <= w_dp_nxt;
        end
    end

    assign an         = r_an;
    assign sseg       = r_sseg;
    assign dp         = r_dp;
    assign frame_done = r_fd;

endmodule

`default_nettype wire
